// File: rtl/dyn_add_sequencer.sv
// Control stage for the 32-bit dynamic adder: holds operands, pulses start,
// waits for ready (bounded by a timeout) and registers the result with a cycle count.
module dyn_add_sequencer #(
    parameter int unsigned W        = 32,
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CW       = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_cin,
    output logic [W-1:0]  add_a,
    output logic [W-1:0]  add_b,
    output logic          add_cin,
    output logic          add_F,
    input  logic          add_R,
    input  logic [W-1:0]  add_sum,
    input  logic          add_cout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic          out_cout,
    output logic          out_timeout,
    output logic [CW-1:0] out_cycles
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    add_a_q, add_a_d;
    logic [W-1:0]    add_b_q, add_b_d;
    logic            add_cin_q, add_cin_d;
    logic            add_f_q, add_f_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_sum_q, out_sum_d;
    logic            out_cout_q, out_cout_d;
    logic            out_timeout_q, out_timeout_d;
    logic [CW-1:0]   out_cycles_q, out_cycles_d;

    // Accept only when idle and the output slot is free or being drained this cycle.
    assign in_ready = (state_q == IDLE) && !reset && (!out_valid_q || out_ready);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        add_a_d       = add_a_q;
        add_b_d       = add_b_q;
        add_cin_d     = add_cin_q;
        add_f_d       = 1'b0;
        out_valid_d   = out_valid_q;
        out_sum_d     = out_sum_q;
        out_cout_d    = out_cout_q;
        out_timeout_d = out_timeout_q;
        out_cycles_d  = out_cycles_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    add_a_d   = in_a;
                    add_b_d   = in_b;
                    add_cin_d = in_cin;
                    add_f_d   = 1'b1;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                count_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (add_R) begin
                    out_sum_d     = add_sum;
                    out_cout_d    = add_cout;
                    out_timeout_d = 1'b0;
                    out_cycles_d  = CW'(count_q + CW'(1));
                    out_valid_d   = 1'b1;
                    state_d       = IDLE;
                end else if (count_q == CW'(MAX_WAIT - 1)) begin
                    // Forced capture: the sum bus may be undriven here.
                    out_sum_d     = add_sum;
                    out_cout_d    = add_cout;
                    out_timeout_d = 1'b1;
                    out_cycles_d  = CW'(MAX_WAIT);
                    out_valid_d   = 1'b1;
                    state_d       = IDLE;
                end else begin
                    count_d = CW'(count_q + CW'(1));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset holds the adder timer cleared via add_F.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            add_a_q       <= '0;
            add_b_q       <= '0;
            add_cin_q     <= 1'b0;
            add_f_q       <= 1'b1;
            out_valid_q   <= 1'b0;
            out_sum_q     <= '0;
            out_cout_q    <= 1'b0;
            out_timeout_q <= 1'b0;
            out_cycles_q  <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            add_a_q       <= add_a_d;
            add_b_q       <= add_b_d;
            add_cin_q     <= add_cin_d;
            add_f_q       <= add_f_d;
            out_valid_q   <= out_valid_d;
            out_sum_q     <= out_sum_d;
            out_cout_q    <= out_cout_d;
            out_timeout_q <= out_timeout_d;
            out_cycles_q  <= out_cycles_d;
        end
    end

    assign add_a       = add_a_q;
    assign add_b       = add_b_q;
    assign add_cin     = add_cin_q;
    assign add_F       = add_f_q;
    assign out_valid   = out_valid_q;
    assign out_sum     = out_sum_q;
    assign out_cout    = out_cout_q;
    assign out_timeout = out_timeout_q;
    assign out_cycles  = out_cycles_q;

endmodule

// File: tb/tb_dyn_add_sequencer.sv
// Randomized bench for dyn_add_sequencer: an operation-level model predicts every
// output each cycle; a small timer-style adder model answers the start pulse.
module tb_dyn_add_sequencer;

    localparam int unsigned W        = 32;
    localparam int unsigned MAX_WAIT = 16;
    localparam int unsigned CW       = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_cin = 1'b0;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_cin;
    logic          add_F;
    logic          add_R = 1'b0;
    logic [W-1:0]  add_sum = '0;
    logic          add_cout = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_timeout;
    logic [CW-1:0] out_cycles;

    always #5 clk = ~clk;

    dyn_add_sequencer #(.W(W), .MAX_WAIT(MAX_WAIT), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_F(add_F),
        .add_R(add_R), .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .out_timeout(out_timeout), .out_cycles(out_cycles)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Operation-level model: an accepted op finishes a fixed number of cycles later.
    int          cyc = 0;
    bit          started = 0;
    bit          m_busy = 0;
    int          m_cap_cyc = 0;
    bit          m_ov = 0;
    logic [31:0] m_sum = '0;
    bit          m_cout = 0, m_to = 0;
    int          m_cycles = 0;
    logic [31:0] m_a = '0, m_b = '0;
    bit          m_cin = 0;
    bit          m_f = 1;
    logic [31:0] p_sum;
    bit          p_cout, p_to;
    int          p_cycles;

    // Adder model: R rises k cycles after F falls and self-holds until the next F.
    int aw = 0;
    int ak = 100000;

    // Snapshots of the last cycle, for hand-computed expectations.
    logic        s_in_ready, s_add_f, s_out_valid;
    int          f_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic one_cycle(input bit rst, input bit vld, input logic [31:0] a,
                             input logic [31:0] b, input bit cin, input bit ordy,
                             input int k);
        bit          m_in_ready, f_now, acc;
        logic [32:0] t;
        @(negedge clk);
        reset = rst; in_valid = vld; in_a = a; in_b = b; in_cin = cin; out_ready = ordy;
        if (!add_F && aw >= ak) begin
            t = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
            add_sum = t[31:0]; add_cout = t[32]; add_R = 1'b1;
        end else begin
            add_sum = 'z; add_cout = 1'b0; add_R = 1'b0;
        end
        #1;
        m_in_ready = !rst && !m_busy && (!m_ov || ordy);
        if (started) begin
            chk("in_ready", 64'(in_ready), 64'(m_in_ready));
            chk("add_F", 64'(add_F), 64'(m_f));
            chk("add_a", 64'(add_a), 64'(m_a));
            chk("add_b", 64'(add_b), 64'(m_b));
            chk("add_cin", 64'(add_cin), 64'(m_cin));
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("out_cout", 64'(out_cout), 64'(m_cout));
            chk("out_timeout", 64'(out_timeout), 64'(m_to));
            chk("out_cycles", 64'(out_cycles), 64'(m_cycles));
            if (!m_to) chk("out_sum", 64'(out_sum), 64'(m_sum));
        end
        s_in_ready = in_ready; s_add_f = add_F; s_out_valid = out_valid;
        f_now = add_F;
        if (f_now) f_cnt++;
        @(posedge clk);
        if (rst) begin
            started = 1; m_busy = 0; m_ov = 0; m_sum = '0; m_cout = 0; m_to = 0;
            m_cycles = 0; m_a = '0; m_b = '0; m_cin = 0; m_f = 1;
        end else begin
            acc = vld && m_in_ready;
            if (m_busy && cyc == m_cap_cyc) begin
                m_busy = 0; m_ov = 1;
                m_sum = p_sum; m_cout = p_cout; m_to = p_to; m_cycles = p_cycles;
            end else if (m_ov && ordy) begin
                m_ov = 0;
            end
            m_f = acc;
            if (acc) begin
                t = {1'b0, a} + {1'b0, b} + 33'(cin);
                p_to     = (k > int'(MAX_WAIT));
                p_cycles = p_to ? int'(MAX_WAIT) : k;
                p_sum    = t[31:0];
                p_cout   = p_to ? 1'b0 : t[32];
                m_busy = 1; m_cap_cyc = cyc + 1 + p_cycles;
                m_a = a; m_b = b; m_cin = cin;
                ak = k;
            end
        end
        if (f_now) aw = 1; else if (aw < 100000) aw++;
        cyc++;
    endtask

    task automatic idle(input bit ordy);
        one_cycle(0, 0, '0, '0, 0, ordy, 1);
    endtask

    task automatic wait_result(input int budget);
        int n;
        n = 0;
        while (!s_out_valid && n < budget) begin
            idle(0);
            n++;
        end
        chk("result_within_budget", 64'(s_out_valid), 64'd1);
    endtask

    initial begin
        int f0;
        bit rst, vld, cin, ordy;
        logic [31:0] a, b;
        int k;

        // Reset, then release: F stays up for the release cycle, then drops.
        repeat (3) one_cycle(1, 1, '0, '0, 0, 0, 1);
        chk("rst_add_F", 64'(s_add_f), 64'd1);
        chk("rst_in_ready", 64'(s_in_ready), 64'd0);
        idle(0);
        idle(0);
        chk("post_rst_add_F", 64'(s_add_f), 64'd0);
        chk("post_rst_in_ready", 64'(s_in_ready), 64'd1);

        // Normal add, R on WAIT cycle 2.
        f0 = f_cnt;
        one_cycle(0, 1, 32'h3, 32'h4, 0, 0, 2);
        wait_result(40);
        chk("norm_F_pulses", 64'(f_cnt - f0), 64'd1);
        chk("norm_sum", 64'(out_sum), 64'h7);
        chk("norm_cout", 64'(out_cout), 64'd0);
        chk("norm_cycles", 64'(out_cycles), 64'd2);
        chk("norm_timeout", 64'(out_timeout), 64'd0);
        idle(1);

        // Long carry chain, R on WAIT cycle 9.
        one_cycle(0, 1, 32'hFFFF_FFFF, 32'h1, 0, 0, 9);
        wait_result(40);
        chk("carry_sum", 64'(out_sum), 64'h0);
        chk("carry_cout", 64'(out_cout), 64'd1);
        chk("carry_cycles", 64'(out_cycles), 64'd9);
        idle(1);

        // Timeout: R never arrives.
        one_cycle(0, 1, 32'h1234, 32'h1, 1, 0, 100000);
        wait_result(40);
        chk("to_timeout", 64'(out_timeout), 64'd1);
        chk("to_cycles", 64'(out_cycles), 64'd16);
        idle(1);
        one_cycle(0, 1, 32'h5, 32'h6, 1, 0, 1);
        wait_result(40);
        chk("after_to_sum", 64'(out_sum), 64'hC);
        chk("after_to_cycles", 64'(out_cycles), 64'd1);
        chk("after_to_timeout", 64'(out_timeout), 64'd0);

        // Backpressure: result held, operand offered for 5 cycles.
        f0 = f_cnt;
        repeat (5) begin
            one_cycle(0, 1, 32'hA, 32'hB, 0, 0, 3);
            chk("bp_in_ready", 64'(s_in_ready), 64'd0);
        end
        chk("bp_no_launch", 64'(f_cnt - f0), 64'd0);
        one_cycle(0, 1, 32'hA, 32'hB, 0, 1, 3);
        chk("bp_release_in_ready", 64'(s_in_ready), 64'd1);
        idle(0);
        chk("bp_launch_F", 64'(s_add_f), 64'd1);
        chk("bp_popped", 64'(s_out_valid), 64'd0);
        wait_result(40);
        chk("bp_sum", 64'(out_sum), 64'h15);
        idle(1);

        // Reset mid-WAIT; R shows up right after release and must be ignored.
        one_cycle(0, 1, 32'h77, 32'h1, 0, 0, 100000);
        repeat (4) idle(0);
        one_cycle(1, 0, '0, '0, 0, 0, 1);
        ak = 1;
        one_cycle(1, 0, '0, '0, 0, 0, 1);
        chk("midrst_F", 64'(s_add_f), 64'd1);
        chk("midrst_ov", 64'(s_out_valid), 64'd0);
        idle(0);
        chk("midrst_rel_F", 64'(s_add_f), 64'd1);
        idle(0);
        chk("midrst_F_low", 64'(s_add_f), 64'd0);
        repeat (4) idle(0);
        chk("midrst_no_result", 64'(s_out_valid), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            vld  = ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 9) < 7);
            cin  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin a = 32'hFFFF_FFFF; b = $urandom; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            k = ($urandom_range(0, 7) == 0) ? 100000 : int'($urandom_range(1, 18));
            one_cycle(rst, vld, a, b, cin, ordy, k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
